// File: rtl/sprite_compositor_if.sv
// Signal bundle between the VGA timing generator, the sprite ROM and the compositor.
// The compositor is the slave; the surrounding pixel pipeline (or a bench) is the master.
interface sprite_compositor_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        pix_valid;
    logic [7:0]  bg_r;
    logic [7:0]  bg_g;
    logic [7:0]  bg_b;
    logic        bg_solid;
    logic [10:0] pos_x;
    logic [10:0] pos_y;
    logic        pos_wr;
    logic [10:0] spr_ix;
    logic [10:0] spr_iy;
    logic [7:0]  spr_r;
    logic [7:0]  spr_g;
    logic [7:0]  spr_b;
    logic        spr_mask;
    logic [7:0]  out_r;
    logic [7:0]  out_g;
    logic [7:0]  out_b;
    logic        out_valid;
    logic        hit;
    logic        collided;
    logic        pos_ack;

    modport slave (
        input  hcount, vcount, pix_valid, bg_r, bg_g, bg_b, bg_solid,
        input  pos_x, pos_y, pos_wr, spr_r, spr_g, spr_b, spr_mask,
        output spr_ix, spr_iy, out_r, out_g, out_b, out_valid, hit, collided, pos_ack
    );

    modport master (
        output hcount, vcount, pix_valid, bg_r, bg_g, bg_b, bg_solid,
        output pos_x, pos_y, pos_wr, spr_r, spr_g, spr_b, spr_mask,
        input  spr_ix, spr_iy, out_r, out_g, out_b, out_valid, hit, collided, pos_ack
    );
endinterface

// File: rtl/sprite_compositor.sv
// Composites a ROM sprite over the background stream with 2-cycle latency, applies
// position updates only at the frame latch point and flags sprite/obstacle collisions.
module sprite_compositor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 43,
    parameter int INIT_X   = 100,
    parameter int INIT_Y   = 200
) (
    input logic                clk,
    input logic                rst_n,
    sprite_compositor_if.slave bus
);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    logic [10:0] act_x, act_y, pend_x, pend_y;
    logic        pend;
    logic [10:0] act_x_nxt, act_y_nxt, pend_x_nxt, pend_y_nxt;
    logic        pend_nxt, ack_nxt;

    logic        line_end, frame_latch;
    logic [10:0] next_line;
    logic [11:0] dx, dy;
    logic        col_in, row_in;

    rgb_t        bg1;
    logic        in1, solid1, valid1;
    logic        draw, hit_nxt;

    assign line_end    = (bus.hcount == 11'(H_ACTIVE));
    assign frame_latch = line_end && (bus.vcount == 11'(V_ACTIVE - 1));

    always_comb begin
        // NOTE: every always_comb output is given a default first, so no branch can leave it unassigned and infer a latch.
        act_x_nxt  = act_x;
        act_y_nxt  = act_y;
        pend_x_nxt = pend_x;
        pend_y_nxt = pend_y;
        pend_nxt   = pend;
        ack_nxt    = 1'b0;
        if (frame_latch && bus.pos_wr) begin
            act_x_nxt = bus.pos_x;
            act_y_nxt = bus.pos_y;
            pend_nxt  = 1'b0;
            ack_nxt   = 1'b1;
        end else if (frame_latch && pend) begin
            act_x_nxt = pend_x;
            act_y_nxt = pend_y;
            pend_nxt  = 1'b0;
            ack_nxt   = 1'b1;
        end else if (bus.pos_wr) begin
            pend_x_nxt = bus.pos_x;
            pend_y_nxt = bus.pos_y;
            pend_nxt   = 1'b1;
        end
    end

    // Row for the coming line uses the position as it stands after a same-cycle latch.
    assign next_line = (bus.vcount == 11'(V_TOTAL - 1)) ? 11'd0 : bus.vcount + 11'd1;
    assign dy        = {1'b0, next_line} - {1'b0, act_y_nxt};
    assign row_in    = !dy[11] && (dy < 12'(SPR_H));

    assign dx        = {1'b0, bus.hcount} - {1'b0, act_x};
    assign col_in    = !dx[11] && (dx < 12'(SPR_W)) && (bus.spr_iy < 11'(SPR_H));

    assign draw      = in1 && bus.spr_mask && valid1;
    assign hit_nxt   = draw && solid1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x       <= 11'(INIT_X);
            act_y       <= 11'(INIT_Y);
            pend_x      <= '0;
            pend_y      <= '0;
            pend        <= 1'b0;
            bus.pos_ack <= 1'b0;
            bus.spr_iy  <= 11'(SPR_H);
            bus.spr_ix  <= 11'(SPR_W);
            in1         <= 1'b0;
            bg1         <= '0;
            solid1      <= 1'b0;
            valid1      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, so stage order in the code is irrelevant.
            act_x       <= act_x_nxt;
            act_y       <= act_y_nxt;
            pend_x      <= pend_x_nxt;
            pend_y      <= pend_y_nxt;
            pend        <= pend_nxt;
            bus.pos_ack <= ack_nxt;
            if (line_end) begin
                bus.spr_iy <= row_in ? dy[10:0] : 11'(SPR_H);
            end
            bus.spr_ix  <= col_in ? dx[10:0] : 11'(SPR_W);
            in1         <= col_in;
            bg1         <= {bus.bg_r, bus.bg_g, bus.bg_b};
            solid1      <= bus.bg_solid;
            valid1      <= bus.pix_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {bus.out_r, bus.out_g, bus.out_b} <= '0;
            bus.out_valid <= 1'b0;
            bus.hit       <= 1'b0;
            bus.collided  <= 1'b0;
        end else begin
            bus.out_valid <= valid1;
            bus.hit       <= hit_nxt;
            // A hit registered on the latch edge belongs to the last pixel of the old frame but still survives the clear.
            bus.collided  <= (bus.collided && !frame_latch) || hit_nxt;
            if (!valid1) begin
                {bus.out_r, bus.out_g, bus.out_b} <= '0;
            end else if (draw) begin
                {bus.out_r, bus.out_g, bus.out_b} <= {bus.spr_r, bus.spr_g, bus.spr_b};
            end else begin
                {bus.out_r, bus.out_g, bus.out_b} <= bg1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a pixel-level reference model checks every
// output each cycle, and literal expectations pin the model at key points.
module tb_sprite_compositor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_compositor_if bus();

    sprite_compositor dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Sprite ROM: colour encodes coordinates; every 7th diagonal is transparent.
    // Out-of-range addresses return an opaque junk colour that must never show.
    function automatic logic [24:0] rom_word(input int ix, input int iy);
        logic [24:0] w;
        if (ix < 0 || ix >= 32 || iy < 0 || iy >= 43)
            w = {1'b1, 24'hEEEEEE};
        else
            w = {(((ix + iy) % 7) != 3), 8'(64 + ix), 8'(128 + iy), 8'(200 + (ix + iy) % 50)};
        return w;
    endfunction

    logic [24:0] rom_q;
    assign rom_q        = rom_word(int'(bus.spr_ix), int'(bus.spr_iy));
    assign bus.spr_mask = rom_q[24];
    assign bus.spr_r    = rom_q[23:16];
    assign bus.spr_g    = rom_q[15:8];
    assign bus.spr_b    = rom_q[7:0];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: expected output state after the next clock edge.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       valid;
        logic       hit;
    } px_t;

    px_t m_stage, m_out;
    int  m_ax, m_ay, m_px, m_py, m_row, m_ix;
    bit  m_pend, m_coll, m_ack;

    // On each falling edge: compare against the last rising edge, then advance
    // the model with the inputs the next rising edge will sample.
    always @(negedge clk) begin : model
        int h, v, dx, dy, nv;
        bit lat, on;
        logic [24:0] w;
        if (!rst_n) begin
            m_ax = 100; m_ay = 200; m_px = 0; m_py = 0;
            m_row = 43; m_ix = 32;
            m_pend = 0; m_coll = 0; m_ack = 0;
            m_stage = '0; m_out = '0;
        end else begin
            check("mdl_out_r",     32'(bus.out_r),     32'(m_out.r));
            check("mdl_out_g",     32'(bus.out_g),     32'(m_out.g));
            check("mdl_out_b",     32'(bus.out_b),     32'(m_out.b));
            check("mdl_out_valid", 32'(bus.out_valid), 32'(m_out.valid));
            check("mdl_hit",       32'(bus.hit),       32'(m_out.hit));
            check("mdl_collided",  32'(bus.collided),  32'(m_coll));
            check("mdl_pos_ack",   32'(bus.pos_ack),   32'(m_ack));
            check("mdl_spr_ix",    32'(bus.spr_ix),    32'(m_ix));
            check("mdl_spr_iy",    32'(bus.spr_iy),    32'(m_row));

            h   = int'(bus.hcount);
            v   = int'(bus.vcount);
            lat = (h == 640) && (v == 479);

            m_out  = m_stage;
            m_coll = (m_coll && !lat) || m_stage.hit;

            dx   = h - m_ax;
            on   = (dx >= 0) && (dx < 32) && (m_row < 43);
            m_ix = on ? dx : 32;
            w    = rom_word(dx, m_row);
            m_stage = '0;
            m_stage.valid = bus.pix_valid;
            if (bus.pix_valid) begin
                if (on && w[24]) begin
                    {m_stage.r, m_stage.g, m_stage.b} = w[23:0];
                    m_stage.hit = bus.bg_solid;
                end else begin
                    {m_stage.r, m_stage.g, m_stage.b} = {bus.bg_r, bus.bg_g, bus.bg_b};
                end
            end

            m_ack = 0;
            if (lat && bus.pos_wr) begin
                m_ax = int'(bus.pos_x); m_ay = int'(bus.pos_y); m_pend = 0; m_ack = 1;
            end else if (lat && m_pend) begin
                m_ax = m_px; m_ay = m_py; m_pend = 0; m_ack = 1;
            end else if (bus.pos_wr) begin
                m_px = int'(bus.pos_x); m_py = int'(bus.pos_y); m_pend = 1;
            end

            if (h == 640) begin
                nv    = (v == 524) ? 0 : v + 1;
                dy    = nv - m_ay;
                m_row = (dy >= 0 && dy < 43) ? dy : 43;
            end
        end
    end

    // One pixel clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic drive(input int h, input int v, input bit valid = 1'b0, input bit solid = 1'b0,
                         input bit wr = 1'b0, input int px = 0, input int py = 0);
        bus.hcount    = 11'(h);
        bus.vcount    = 11'(v);
        bus.pix_valid = valid;
        bus.bg_r      = 8'h10;
        bus.bg_g      = 8'(h);
        bus.bg_b      = 8'(v);
        bus.bg_solid  = solid;
        bus.pos_wr    = wr;
        bus.pos_x     = 11'(px);
        bus.pos_y     = 11'(py);
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) drive(h, v, h < 640);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.hcount = '0; bus.vcount = '0; bus.pix_valid = 1'b0;
        bus.bg_r = '0; bus.bg_g = '0; bus.bg_b = '0; bus.bg_solid = 1'b0;
        bus.pos_x = '0; bus.pos_y = '0; bus.pos_wr = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_spr_ix",   32'(bus.spr_ix),    32);
        check("rst_spr_iy",   32'(bus.spr_iy),    43);
        check("rst_out",      32'({bus.out_r, bus.out_g, bus.out_b}), 0);
        check("rst_flags",    32'({bus.out_valid, bus.hit, bus.collided, bus.pos_ack}), 0);
        rst_n = 1'b1;

        // Reset position (100,200): first sprite pixel and its left neighbour.
        drive(640, 199);
        check("row0_iy", 32'(bus.spr_iy), 0);
        for (int h = 96; h <= 104; h++) begin
            drive(h, 200, 1'b1);
            if (h == 100) begin
                check("col0_ix",   32'(bus.spr_ix), 0);
                check("left_bg_r", 32'(bus.out_r),  32'h10);
                check("left_bg_g", 32'(bus.out_g),  99);
            end
            if (h == 101) check("first_px", 32'({bus.out_r, bus.out_g, bus.out_b}), 32'h4080C8);
        end
        drive(640, 200);

        // Mid-frame write stays pending until the frame latch.
        drive(5, 100, 1'b1, 1'b0, 1'b1, 300, 50);
        check("no_early_ack", 32'(bus.pos_ack), 0);
        scan(201, 98, 104);
        drive(640, 479);
        check("latch_ack", 32'(bus.pos_ack), 1);
        drive(641, 479);
        check("ack_pulse", 32'(bus.pos_ack), 0);
        drive(640, 49);
        check("new_row0_iy", 32'(bus.spr_iy), 0);
        for (int h = 298; h <= 304; h++) begin
            drive(h, 50, 1'b1);
            if (h == 301) check("new_pos_px_r", 32'(bus.out_r), 32'h40);
        end
        drive(640, 199);
        check("old_row_gone", 32'(bus.spr_iy), 43);
        scan(200, 98, 104);

        // Write coincident with the latch, sprite hanging off the bottom-right corner.
        drive(640, 479, 1'b0, 1'b0, 1'b1, 630, 470);
        check("coinc_ack", 32'(bus.pos_ack), 1);
        drive(641, 479);
        check("coinc_ack_once", 32'(bus.pos_ack), 0);
        drive(640, 469);
        check("edge_row0_iy", 32'(bus.spr_iy), 0);
        scan(470, 626, 645);
        drive(640, 478);
        check("edge_row9_iy", 32'(bus.spr_iy), 9);
        scan(479, 628, 639);
        drive(640, 524);
        check("no_wrap_top", 32'(bus.spr_iy), 43);
        scan(0, 0, 12);

        // Collision: obstacles under a transparent (x=100) and an opaque (x=110) sprite pixel.
        drive(3, 0, 1'b0, 1'b0, 1'b1, 100, 200);
        drive(640, 479);
        drive(640, 209);
        for (int h = 98; h <= 114; h++) begin
            drive(h, 210, 1'b1, (h == 100) || (h == 110));
            if (h == 101) check("no_hit_transparent", 32'(bus.hit), 0);
            if (h == 111) check("hit_pulse", 32'({bus.hit, bus.collided}), 32'b11);
            if (h == 112) check("hit_sticky", 32'({bus.hit, bus.collided}), 32'b01);
        end
        drive(641, 210);
        drive(642, 210);
        check("coll_held", 32'(bus.collided), 1);
        drive(640, 479);
        check("coll_cleared", 32'(bus.collided), 0);
        check("no_pend_no_ack", 32'(bus.pos_ack), 0);

        // Reset mid-line with a pending write and a live collision.
        drive(3, 0, 1'b0, 1'b0, 1'b1, 5, 5);
        drive(640, 209);
        for (int h = 100; h <= 105; h++) drive(h, 210, 1'b1, h == 102);
        check("pre_rst_coll", 32'({bus.out_valid, bus.collided}), 32'b11);
        rst_n = 1'b0;
        #1;
        check("midrst_out",   32'({bus.out_r, bus.out_g, bus.out_b}), 0);
        check("midrst_flags", 32'({bus.out_valid, bus.hit, bus.collided, bus.pos_ack}), 0);
        check("midrst_ix",    32'(bus.spr_ix), 32);
        check("midrst_iy",    32'(bus.spr_iy), 43);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(640, 479);
        check("pend_discarded", 32'(bus.pos_ack), 0);
        drive(640, 199);
        check("act_restored_iy", 32'(bus.spr_iy), 0);
        scan(200, 98, 103);
        drive(640, 200);
        drive(641, 200);
        drive(642, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
